// File: rtl/uart_ram_dump_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_ram_dump_tx_if
// Purpose  : Bundles the dump transmitter's control, RAM read port and UART
//            line signals. master = transmitter, slave = RAM/host side.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_ram_dump_tx_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
);
    logic              start;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (
        input  start,
        input  rd_data,
        output rd_addr,
        output tx,
        output busy,
        output done
    );

    modport slave (
        output start,
        output rd_data,
        input  rd_addr,
        input  tx,
        input  busy,
        input  done
    );
endinterface
`default_nettype wire

// File: rtl/uart_ram_dump_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_ram_dump_tx
// Purpose  : Reads the nibble RAM back one address at a time and sends each
//            word as an uppercase ASCII hex character over UART 8N1, ending
//            the dump with CR, LF.
// Revision : 1.0 - initial release
// ============================================================================
module uart_ram_dump_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 32,
    parameter int DATA_W       = 4
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    uart_ram_dump_tx_if.master   bus
);
    localparam int C_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int C_CHAR_W = $clog2(DEPTH + 2);

    localparam logic [C_BAUD_W-1:0] c_BAUD_LAST = C_BAUD_W'(CLKS_PER_BIT - 1);
    // Character indices past the RAM contents select the line terminator.
    localparam logic [C_CHAR_W-1:0] c_CHAR_CR   = C_CHAR_W'(DEPTH);
    localparam logic [C_CHAR_W-1:0] c_CHAR_LF   = C_CHAR_W'(DEPTH + 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_LATCH = 3'd2;
    localparam logic [2:0] c_START = 3'd3;
    localparam logic [2:0] c_DATA  = 3'd4;
    localparam logic [2:0] c_STOP  = 3'd5;
    localparam logic [2:0] c_NEXT  = 3'd6;

    logic [2:0]          r_state;
    logic [C_BAUD_W-1:0] r_baud;
    logic [2:0]          r_bit;
    logic [C_CHAR_W-1:0] r_char;
    logic [7:0]          r_shift;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;

    logic [C_CHAR_W-1:0] w_char_next;
    logic                w_baud_last;

    // 0..9 map to '0'..'9'; 10..15 map to 'A'..'F' (0x41 + v - 10 = 0x37 + v).
    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        if (v < 4'd10)
            hex_ascii = 8'h30 + {4'h0, v};
        else
            hex_ascii = 8'h37 + {4'h0, v};
    endfunction

    assign w_char_next = r_char + C_CHAR_W'(1);
    assign w_baud_last = (r_baud == c_BAUD_LAST);

    // Dump sequencer: fetch, latch, then serialise one character per frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_IDLE;
            r_baud    <= '0;
            r_bit     <= '0;
            r_char    <= '0;
            r_shift   <= '0;
            r_rd_addr <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (bus.start) begin
                        r_rd_addr <= '0;
                        r_char    <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= c_FETCH;
                    end
                end
                // One cycle for the RAM's registered address to take effect.
                c_FETCH: r_state <= c_LATCH;
                c_LATCH: begin
                    if (r_char == c_CHAR_CR)
                        r_shift <= 8'h0D;
                    else if (r_char == c_CHAR_LF)
                        r_shift <= 8'h0A;
                    else
                        r_shift <= hex_ascii(bus.rd_data);
                    r_baud  <= '0;
                    r_tx    <= 1'b0;
                    r_state <= c_START;
                end
                c_START: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= c_DATA;
                    end else begin
                        r_baud <= r_baud + C_BAUD_W'(1);
                    end
                end
                c_DATA: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= c_STOP;
                        end else begin
                            // Next bit on the line is what becomes shift[0].
                            r_tx <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + C_BAUD_W'(1);
                    end
                end
                c_STOP: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        // Registered so done is visible exactly in NEXT.
                        r_done  <= (r_char == c_CHAR_LF);
                        r_state <= c_NEXT;
                    end else begin
                        r_baud <= r_baud + C_BAUD_W'(1);
                    end
                end
                c_NEXT: begin
                    if (r_char == c_CHAR_LF) begin
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end else begin
                        r_char <= w_char_next;
                        if (w_char_next < c_CHAR_CR)
                            r_rd_addr <= ADDR_W'(w_char_next);
                        r_state <= c_FETCH;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.rd_addr = r_rd_addr;
    assign bus.tx      = r_tx;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule
`default_nettype wire

// File: tb/tb_uart_ram_dump_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_ram_dump_tx
// Purpose  : Self-checking bench for uart_ram_dump_tx. A small instance
//            (4 clocks/bit, 4 words) runs table-driven dumps and corner
//            cases; a 32-word instance runs random RAM contents against a
//            hex-string reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_ram_dump_tx;
    localparam int CPB_A = 4;
    localparam int DEP_A = 4;
    localparam int CPB_B = 5;
    localparam int DEP_B = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_ram_dump_tx_if #(.ADDR_W(5), .DATA_W(4)) ifa ();
    uart_ram_dump_tx_if #(.ADDR_W(5), .DATA_W(4)) ifb ();

    uart_ram_dump_tx #(.CLKS_PER_BIT(CPB_A), .ADDR_W(5), .DEPTH(DEP_A), .DATA_W(4)) dut_a (
        .clk(clk), .reset_n(rst_n), .bus(ifa));
    uart_ram_dump_tx #(.CLKS_PER_BIT(CPB_B), .ADDR_W(5), .DEPTH(DEP_B), .DATA_W(4)) dut_b (
        .clk(clk), .reset_n(rst_n), .bus(ifb));

    // RAM models: registered read, q follows the address one edge later.
    logic [3:0] mem_a [32];
    logic [3:0] mem_b [32];
    always @(posedge clk) ifa.rd_data <= mem_a[ifa.rd_addr];
    always @(posedge clk) ifb.rd_data <= mem_b[ifb.rd_addr];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle trace of the selected instance, sampled 1 time unit after clk.
    bit         rec_on = 1'b0;
    bit         sel_b  = 1'b0;
    logic       rec_tx   [$];
    logic       rec_done [$];
    logic       rec_busy [$];
    int         rec_addr [$];
    always @(posedge clk) begin
        #1;
        if (rec_on) begin
            if (sel_b) begin
                rec_tx.push_back(ifb.tx);   rec_done.push_back(ifb.done);
                rec_busy.push_back(ifb.busy); rec_addr.push_back(int'(ifb.rd_addr));
            end else begin
                rec_tx.push_back(ifa.tx);   rec_done.push_back(ifa.done);
                rec_busy.push_back(ifa.busy); rec_addr.push_back(int'(ifa.rd_addr));
            end
        end
    end

    logic [7:0] got  [$];
    logic [7:0] expq [$];
    int         fst  [$];

    // Reference: each word becomes one character of "0123456789ABCDEF".
    task automatic model_expected(input bit use_b);
        string hx;
        int    dep;
        hx  = "0123456789ABCDEF";
        dep = use_b ? DEP_B : DEP_A;
        expq.delete();
        for (int k = 0; k < dep; k++)
            expq.push_back(hx[use_b ? mem_b[k] : mem_a[k]]);
        expq.push_back(8'h0D);
        expq.push_back(8'h0A);
    endtask

    // Find frames in the trace; every bit level must hold for exactly cpb samples.
    task automatic decode(input int cpb);
        int i;
        got.delete(); fst.delete();
        i = 0;
        while (i + 10 * cpb <= rec_tx.size()) begin
            if (rec_tx[i] == 1'b0) begin
                logic [7:0] b;
                int tbad;
                tbad = 0;
                for (int s = 0; s < 10; s++)
                    for (int k = 0; k < cpb; k++)
                        if (rec_tx[i + s * cpb + k] !== rec_tx[i + s * cpb]) tbad++;
                for (int s = 0; s < 8; s++) b[s] = rec_tx[i + (s + 1) * cpb];
                if (rec_tx[i + 9 * cpb] !== 1'b1) tbad++;
                chk("frame_level_hold", tbad, 0);
                got.push_back(b);
                fst.push_back(i);
                i += 10 * cpb;
            end else begin
                i++;
            end
        end
    endtask

    task automatic check_dump(input string tag, input int cpb);
        int ndone, idone;
        decode(cpb);
        chk({tag, "_frames"}, got.size(), expq.size());
        for (int k = 0; k < expq.size() && k < got.size(); k++)
            chk($sformatf("%s_byte%0d", tag, k), int'(got[k]), int'(expq[k]));
        if (fst.size() > 0) chk({tag, "_first_start"}, fst[0], 2);
        for (int k = 1; k < fst.size(); k++)
            chk($sformatf("%s_gap%0d", tag, k), fst[k] - (fst[k-1] + 10 * cpb), 3);
        ndone = 0; idone = -1;
        foreach (rec_done[k]) if (rec_done[k] === 1'b1) begin ndone++; idone = k; end
        chk({tag, "_done_count"}, ndone, 1);
        if (rec_busy.size() > 0) chk({tag, "_busy_rise"}, int'(rec_busy[0]), 1);
        if (idone >= 0 && fst.size() > 0 && idone + 1 < rec_busy.size()) begin
            chk({tag, "_done_pos"}, idone, fst[fst.size()-1] + 10 * cpb);
            chk({tag, "_busy_at_done"}, int'(rec_busy[idone]), 1);
            chk({tag, "_busy_after_done"}, int'(rec_busy[idone + 1]), 0);
        end
    endtask

    task automatic check_addr_seq(input string tag, input int n);
        int seq [$];
        foreach (rec_addr[k])
            if (seq.size() == 0 || seq[seq.size()-1] != rec_addr[k]) seq.push_back(rec_addr[k]);
        chk({tag, "_addr_seq_len"}, seq.size(), n);
        for (int k = 0; k < n && k < seq.size(); k++)
            chk($sformatf("%s_addr%0d", tag, k), seq[k], k);
    endtask

    // Pulse start, trace until done plus 5 cycles; optional mid-dump start
    // (instance A) or rewrite of not-yet-sent words (instance B).
    task automatic run_dump(input bit use_b, input int mid_addr, input bit rewrite, input int budget);
        int cyc, after, cd;
        bit seen, pulsed, rewrote;
        rec_tx.delete(); rec_done.delete(); rec_busy.delete(); rec_addr.delete();
        sel_b = use_b;
        @(negedge clk);
        if (use_b) ifb.start = 1'b1; else ifa.start = 1'b1;
        rec_on = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0; ifb.start = 1'b0;
        cyc = 0; after = 0; cd = 0; seen = 0; pulsed = 0; rewrote = 0;
        while (after < 5 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            ifa.start = 1'b0;
            if (seen) after++;
            else if (rec_done.size() > 0 && rec_done[rec_done.size()-1] === 1'b1) seen = 1;
            if (!use_b && mid_addr >= 0 && !pulsed && int'(ifa.rd_addr) == mid_addr) begin
                pulsed = 1; cd = 10;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) ifa.start = 1'b1;
            end
            if (use_b && rewrite && !rewrote && ifb.rd_addr == 5'd10) begin
                for (int k = 20; k < 32; k++) mem_b[k] = 4'($urandom);
                rewrote = 1;
            end
        end
        ifa.start = 1'b0;
        chk("dump_completed_in_budget", int'(seen), 1);
        rec_on = 1'b0;
    endtask

    typedef struct {
        logic [15:0] ram;     // word 0 in the top nibble
        logic [47:0] exp;     // first character in the top byte
    } vec_t;
    vec_t vt [5];

    initial begin
        int lows, cyc;
        logic [9:0] pat_a;
        vt[0] = '{16'h3AF0, {"3AF0", 8'h0D, 8'h0A}};
        vt[1] = '{16'h91B5, {"91B5", 8'h0D, 8'h0A}};
        vt[2] = '{16'h0000, {"0000", 8'h0D, 8'h0A}};
        vt[3] = '{16'hFEDC, {"FEDC", 8'h0D, 8'h0A}};
        vt[4] = '{16'h7C28, {"7C28", 8'h0D, 8'h0A}};
        pat_a = 10'b1010000010;   // level s of 'A' frame is pat_a[s]

        ifa.start = 1'b0; ifb.start = 1'b0;
        for (int k = 0; k < 32; k++) begin mem_a[k] = 4'h0; mem_b[k] = 4'h0; end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", int'(ifa.tx), 1);
        chk("reset_busy", int'(ifa.busy), 0);
        chk("reset_done", int'(ifa.done), 0);
        chk("reset_rd_addr", int'(ifa.rd_addr), 0);
        rst_n = 1'b1;

        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifa.tx !== 1'b1 || ifa.busy !== 1'b0) lows++;
        end
        chk("idle_no_start", lows, 0);

        // Table of RAM images with hand-written expected character streams.
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) mem_a[k] = vt[r].ram[15 - 4 * k -: 4];
            expq.delete();
            for (int k = 0; k < 6; k++) expq.push_back(vt[r].exp[47 - 8 * k -: 8]);
            run_dump(1'b0, -1, 1'b0, 400);
            check_dump($sformatf("row%0d", r), CPB_A);
            check_addr_seq($sformatf("row%0d", r), 4);
            if (r == 0 && fst.size() > 1)
                for (int s = 0; s < 10; s++)
                    chk($sformatf("A_level%0d", s), int'(rec_tx[fst[1] + s * CPB_A]), int'(pat_a[s]));
        end

        // Start pulsed again while char 2 is on the line: must be ignored.
        for (int k = 0; k < 4; k++) mem_a[k] = vt[0].ram[15 - 4 * k -: 4];
        expq.delete();
        for (int k = 0; k < 6; k++) expq.push_back(vt[0].exp[47 - 8 * k -: 8]);
        run_dump(1'b0, 2, 1'b0, 400);
        check_dump("midstart", CPB_A);
        check_addr_seq("midstart", 4);

        // Reset during the data bits of char 1 ('A', bit 1 is low).
        @(negedge clk); ifa.start = 1'b1;
        @(negedge clk); ifa.start = 1'b0;
        cyc = 0;
        while (ifa.rd_addr != 5'd1 && cyc < 200) begin @(negedge clk); cyc++; end
        chk("reach_char1", int'(cyc < 200), 1);
        repeat (13) @(negedge clk);
        chk("pre_reset_tx_low", int'(ifa.tx), 0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_tx", int'(ifa.tx), 1);
        chk("async_reset_busy", int'(ifa.busy), 0);
        chk("async_reset_addr", int'(ifa.rd_addr), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_dump(1'b0, -1, 1'b0, 400);
        check_dump("after_reset", CPB_A);
        check_addr_seq("after_reset", 4);

        // 32-word instance: random contents, upper words rewritten mid-dump.
        for (int k = 0; k < 32; k++) mem_b[k] = 4'($urandom);
        run_dump(1'b1, -1, 1'b1, 4000);
        model_expected(1'b1);
        check_dump("rand", CPB_B);
        check_addr_seq("rand", 32);

        for (int k = 0; k < 32; k++) mem_b[k] = 4'h9;
        run_dump(1'b1, -1, 1'b0, 4000);
        model_expected(1'b1);
        check_dump("all9", CPB_B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
